// File: rtl/aes_key_expander_seq_pkg.sv
// Shared definitions for the sequential AES-128 key expander.
// Contents: FSM state encoding, AES key-schedule constants, the xtime and
// RotWord helpers, and the FIPS-197 keys used by the known-answer benches.
package aes_key_expander_seq_pkg;

    localparam int AES_NK    = 4;
    localparam int AES_NR    = 10;
    localparam int AES_KEY_W = 128;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXPAND = 2'd1,
        ST_DONE   = 2'd2
    } kx_state_t;

    // GF(2^8) multiply by x, reduced by the AES polynomial (0x11b).
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Cyclic left rotation of a word by one byte.
    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    // FIPS-197 appendix C.1 key and appendix A.1 key.
    localparam logic [127:0] FIPS_C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_A1_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

endpackage

// File: rtl/aes_key_expander_seq_if.sv
// Key-load handshake and round-key read bus of the key expander.
//   key_valid/key_ready/key_in : key load handshake (master drives key)
//   busy/keys_valid            : expansion status
//   rk_addr/rk_data            : round-key read port (1-cycle latency)
interface aes_key_expander_seq_if;
    import aes_key_expander_seq_pkg::*;

    logic                 key_valid;
    logic                 key_ready;
    logic [AES_KEY_W-1:0] key_in;
    logic                 busy;
    logic                 keys_valid;
    logic [3:0]           rk_addr;
    logic [AES_KEY_W-1:0] rk_data;

    modport master (
        output key_valid, key_in, rk_addr,
        input  key_ready, busy, keys_valid, rk_data
    );

    modport slave (
        input  key_valid, key_in, rk_addr,
        output key_ready, busy, keys_valid, rk_data
    );

endinterface

// File: rtl/aes_key_expander_seq_sbox.sv
// Combinational AES forward S-box.
//   i_in  : input byte
//   o_out : substituted byte
module aes_key_expander_seq_sbox (
    input  logic [7:0] i_in,
    output logic [7:0] o_out
);

    // Forward S-box lookup table.
    always_comb begin
        o_out = 8'h00;
        case (i_in)
            8'h00: o_out = 8'h63; 8'h01: o_out = 8'h7c; 8'h02: o_out = 8'h77; 8'h03: o_out = 8'h7b; 8'h04: o_out = 8'hf2; 8'h05: o_out = 8'h6b; 8'h06: o_out = 8'h6f; 8'h07: o_out = 8'hc5;
            8'h08: o_out = 8'h30; 8'h09: o_out = 8'h01; 8'h0a: o_out = 8'h67; 8'h0b: o_out = 8'h2b; 8'h0c: o_out = 8'hfe; 8'h0d: o_out = 8'hd7; 8'h0e: o_out = 8'hab; 8'h0f: o_out = 8'h76;
            8'h10: o_out = 8'hca; 8'h11: o_out = 8'h82; 8'h12: o_out = 8'hc9; 8'h13: o_out = 8'h7d; 8'h14: o_out = 8'hfa; 8'h15: o_out = 8'h59; 8'h16: o_out = 8'h47; 8'h17: o_out = 8'hf0;
            8'h18: o_out = 8'had; 8'h19: o_out = 8'hd4; 8'h1a: o_out = 8'ha2; 8'h1b: o_out = 8'haf; 8'h1c: o_out = 8'h9c; 8'h1d: o_out = 8'ha4; 8'h1e: o_out = 8'h72; 8'h1f: o_out = 8'hc0;
            8'h20: o_out = 8'hb7; 8'h21: o_out = 8'hfd; 8'h22: o_out = 8'h93; 8'h23: o_out = 8'h26; 8'h24: o_out = 8'h36; 8'h25: o_out = 8'h3f; 8'h26: o_out = 8'hf7; 8'h27: o_out = 8'hcc;
            8'h28: o_out = 8'h34; 8'h29: o_out = 8'ha5; 8'h2a: o_out = 8'he5; 8'h2b: o_out = 8'hf1; 8'h2c: o_out = 8'h71; 8'h2d: o_out = 8'hd8; 8'h2e: o_out = 8'h31; 8'h2f: o_out = 8'h15;
            8'h30: o_out = 8'h04; 8'h31: o_out = 8'hc7; 8'h32: o_out = 8'h23; 8'h33: o_out = 8'hc3; 8'h34: o_out = 8'h18; 8'h35: o_out = 8'h96; 8'h36: o_out = 8'h05; 8'h37: o_out = 8'h9a;
            8'h38: o_out = 8'h07; 8'h39: o_out = 8'h12; 8'h3a: o_out = 8'h80; 8'h3b: o_out = 8'he2; 8'h3c: o_out = 8'heb; 8'h3d: o_out = 8'h27; 8'h3e: o_out = 8'hb2; 8'h3f: o_out = 8'h75;
            8'h40: o_out = 8'h09; 8'h41: o_out = 8'h83; 8'h42: o_out = 8'h2c; 8'h43: o_out = 8'h1a; 8'h44: o_out = 8'h1b; 8'h45: o_out = 8'h6e; 8'h46: o_out = 8'h5a; 8'h47: o_out = 8'ha0;
            8'h48: o_out = 8'h52; 8'h49: o_out = 8'h3b; 8'h4a: o_out = 8'hd6; 8'h4b: o_out = 8'hb3; 8'h4c: o_out = 8'h29; 8'h4d: o_out = 8'he3; 8'h4e: o_out = 8'h2f; 8'h4f: o_out = 8'h84;
            8'h50: o_out = 8'h53; 8'h51: o_out = 8'hd1; 8'h52: o_out = 8'h00; 8'h53: o_out = 8'hed; 8'h54: o_out = 8'h20; 8'h55: o_out = 8'hfc; 8'h56: o_out = 8'hb1; 8'h57: o_out = 8'h5b;
            8'h58: o_out = 8'h6a; 8'h59: o_out = 8'hcb; 8'h5a: o_out = 8'hbe; 8'h5b: o_out = 8'h39; 8'h5c: o_out = 8'h4a; 8'h5d: o_out = 8'h4c; 8'h5e: o_out = 8'h58; 8'h5f: o_out = 8'hcf;
            8'h60: o_out = 8'hd0; 8'h61: o_out = 8'hef; 8'h62: o_out = 8'haa; 8'h63: o_out = 8'hfb; 8'h64: o_out = 8'h43; 8'h65: o_out = 8'h4d; 8'h66: o_out = 8'h33; 8'h67: o_out = 8'h85;
            8'h68: o_out = 8'h45; 8'h69: o_out = 8'hf9; 8'h6a: o_out = 8'h02; 8'h6b: o_out = 8'h7f; 8'h6c: o_out = 8'h50; 8'h6d: o_out = 8'h3c; 8'h6e: o_out = 8'h9f; 8'h6f: o_out = 8'ha8;
            8'h70: o_out = 8'h51; 8'h71: o_out = 8'ha3; 8'h72: o_out = 8'h40; 8'h73: o_out = 8'h8f; 8'h74: o_out = 8'h92; 8'h75: o_out = 8'h9d; 8'h76: o_out = 8'h38; 8'h77: o_out = 8'hf5;
            8'h78: o_out = 8'hbc; 8'h79: o_out = 8'hb6; 8'h7a: o_out = 8'hda; 8'h7b: o_out = 8'h21; 8'h7c: o_out = 8'h10; 8'h7d: o_out = 8'hff; 8'h7e: o_out = 8'hf3; 8'h7f: o_out = 8'hd2;
            8'h80: o_out = 8'hcd; 8'h81: o_out = 8'h0c; 8'h82: o_out = 8'h13; 8'h83: o_out = 8'hec; 8'h84: o_out = 8'h5f; 8'h85: o_out = 8'h97; 8'h86: o_out = 8'h44; 8'h87: o_out = 8'h17;
            8'h88: o_out = 8'hc4; 8'h89: o_out = 8'ha7; 8'h8a: o_out = 8'h7e; 8'h8b: o_out = 8'h3d; 8'h8c: o_out = 8'h64; 8'h8d: o_out = 8'h5d; 8'h8e: o_out = 8'h19; 8'h8f: o_out = 8'h73;
            8'h90: o_out = 8'h60; 8'h91: o_out = 8'h81; 8'h92: o_out = 8'h4f; 8'h93: o_out = 8'hdc; 8'h94: o_out = 8'h22; 8'h95: o_out = 8'h2a; 8'h96: o_out = 8'h90; 8'h97: o_out = 8'h88;
            8'h98: o_out = 8'h46; 8'h99: o_out = 8'hee; 8'h9a: o_out = 8'hb8; 8'h9b: o_out = 8'h14; 8'h9c: o_out = 8'hde; 8'h9d: o_out = 8'h5e; 8'h9e: o_out = 8'h0b; 8'h9f: o_out = 8'hdb;
            8'ha0: o_out = 8'he0; 8'ha1: o_out = 8'h32; 8'ha2: o_out = 8'h3a; 8'ha3: o_out = 8'h0a; 8'ha4: o_out = 8'h49; 8'ha5: o_out = 8'h06; 8'ha6: o_out = 8'h24; 8'ha7: o_out = 8'h5c;
            8'ha8: o_out = 8'hc2; 8'ha9: o_out = 8'hd3; 8'haa: o_out = 8'hac; 8'hab: o_out = 8'h62; 8'hac: o_out = 8'h91; 8'had: o_out = 8'h95; 8'hae: o_out = 8'he4; 8'haf: o_out = 8'h79;
            8'hb0: o_out = 8'he7; 8'hb1: o_out = 8'hc8; 8'hb2: o_out = 8'h37; 8'hb3: o_out = 8'h6d; 8'hb4: o_out = 8'h8d; 8'hb5: o_out = 8'hd5; 8'hb6: o_out = 8'h4e; 8'hb7: o_out = 8'ha9;
            8'hb8: o_out = 8'h6c; 8'hb9: o_out = 8'h56; 8'hba: o_out = 8'hf4; 8'hbb: o_out = 8'hea; 8'hbc: o_out = 8'h65; 8'hbd: o_out = 8'h7a; 8'hbe: o_out = 8'hae; 8'hbf: o_out = 8'h08;
            8'hc0: o_out = 8'hba; 8'hc1: o_out = 8'h78; 8'hc2: o_out = 8'h25; 8'hc3: o_out = 8'h2e; 8'hc4: o_out = 8'h1c; 8'hc5: o_out = 8'ha6; 8'hc6: o_out = 8'hb4; 8'hc7: o_out = 8'hc6;
            8'hc8: o_out = 8'he8; 8'hc9: o_out = 8'hdd; 8'hca: o_out = 8'h74; 8'hcb: o_out = 8'h1f; 8'hcc: o_out = 8'h4b; 8'hcd: o_out = 8'hbd; 8'hce: o_out = 8'h8b; 8'hcf: o_out = 8'h8a;
            8'hd0: o_out = 8'h70; 8'hd1: o_out = 8'h3e; 8'hd2: o_out = 8'hb5; 8'hd3: o_out = 8'h66; 8'hd4: o_out = 8'h48; 8'hd5: o_out = 8'h03; 8'hd6: o_out = 8'hf6; 8'hd7: o_out = 8'h0e;
            8'hd8: o_out = 8'h61; 8'hd9: o_out = 8'h35; 8'hda: o_out = 8'h57; 8'hdb: o_out = 8'hb9; 8'hdc: o_out = 8'h86; 8'hdd: o_out = 8'hc1; 8'hde: o_out = 8'h1d; 8'hdf: o_out = 8'h9e;
            8'he0: o_out = 8'he1; 8'he1: o_out = 8'hf8; 8'he2: o_out = 8'h98; 8'he3: o_out = 8'h11; 8'he4: o_out = 8'h69; 8'he5: o_out = 8'hd9; 8'he6: o_out = 8'h8e; 8'he7: o_out = 8'h94;
            8'he8: o_out = 8'h9b; 8'he9: o_out = 8'h1e; 8'hea: o_out = 8'h87; 8'heb: o_out = 8'he9; 8'hec: o_out = 8'hce; 8'hed: o_out = 8'h55; 8'hee: o_out = 8'h28; 8'hef: o_out = 8'hdf;
            8'hf0: o_out = 8'h8c; 8'hf1: o_out = 8'ha1; 8'hf2: o_out = 8'h89; 8'hf3: o_out = 8'h0d; 8'hf4: o_out = 8'hbf; 8'hf5: o_out = 8'he6; 8'hf6: o_out = 8'h42; 8'hf7: o_out = 8'h68;
            8'hf8: o_out = 8'h41; 8'hf9: o_out = 8'h99; 8'hfa: o_out = 8'h2d; 8'hfb: o_out = 8'h0f; 8'hfc: o_out = 8'hb0; 8'hfd: o_out = 8'h54; 8'hfe: o_out = 8'hbb; 8'hff: o_out = 8'h16;
            default: o_out = 8'h00;
        endcase
    end

endmodule

// File: rtl/aes_key_expander_seq.sv
// Sequential AES-128 key schedule. Accepts a cipher key over a valid/ready
// handshake, then produces one round key per clock into an 11-entry store.
// Consumers read round keys by index through a registered read port and
// must gate on keys_valid.
//   i_clk   : clock, all state on the rising edge
//   i_reset : synchronous active-high reset
//   if_kx   : key handshake, status and round-key read bus (slave side)
module aes_key_expander_seq
    import aes_key_expander_seq_pkg::*;
#(
    parameter int NK    = AES_NK,
    parameter int NR    = AES_NR,
    parameter int KEY_W = AES_KEY_W
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    aes_key_expander_seq_if.slave if_kx
);

    if (NK != 4 || NR != 10 || KEY_W != 32 * NK) begin : g_param_err
        $error("aes_key_expander_seq supports only AES-128 (NK=4, NR=10, KEY_W=128)");
    end

    localparam logic [3:0] LP_NR = 4'(NR);

    kx_state_t          r_state;
    kx_state_t          w_next_state;
    logic [3:0]         r_round;
    logic [7:0]         r_rcon;
    logic               r_keys_valid;
    logic [KEY_W-1:0]   r_work;      // most recent round key, seeds the next one
    logic [KEY_W-1:0]   r_rk_data;
    logic [KEY_W-1:0]   r_store [0:NR];

    logic               w_key_ready;
    logic               w_accept;
    logic               w_we;
    logic [3:0]         w_waddr;
    logic [KEY_W-1:0]   w_wdata;
    logic [31:0]        w_rot;
    logic [31:0]        w_sub;
    logic [31:0]        w_w0;
    logic [31:0]        w_w1;
    logic [31:0]        w_w2;
    logic [31:0]        w_w3;

    assign w_key_ready = ~i_reset & (r_state != ST_EXPAND);
    assign w_accept    = if_kx.key_valid & w_key_ready;

    // SubWord(RotWord(w3)) using four S-box lanes.
    assign w_rot = rot_word(r_work[31:0]);
    for (genvar g = 0; g < 4; g++) begin : g_sbox
        aes_key_expander_seq_sbox u_sbox (
            .i_in  (w_rot[8*g +: 8]),
            .o_out (w_sub[8*g +: 8])
        );
    end

    assign w_w0 = r_work[127:96] ^ w_sub ^ {r_rcon, 24'h000000};
    assign w_w1 = r_work[95:64]  ^ w_w0;
    assign w_w2 = r_work[63:32]  ^ w_w1;
    assign w_w3 = r_work[31:0]   ^ w_w2;

    // Store write port: the cipher key on accept, otherwise the round being expanded.
    assign w_we    = ~i_reset & (w_accept | (r_state == ST_EXPAND));
    assign w_waddr = w_accept ? 4'd0 : r_round;
    assign w_wdata = w_accept ? if_kx.key_in : {w_w0, w_w1, w_w2, w_w3};

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) w_next_state = ST_EXPAND;
                else          w_next_state = ST_IDLE;
            end
            ST_EXPAND: begin
                if (r_round == LP_NR) w_next_state = ST_DONE;
                else                  w_next_state = ST_EXPAND;
            end
            ST_DONE: begin
                if (w_accept) w_next_state = ST_EXPAND;
                else          w_next_state = ST_DONE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // State, round counter, rcon, working key, status and read-data registers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= ST_IDLE;
            r_round      <= 4'd0;
            r_rcon       <= 8'h01;
            r_keys_valid <= 1'b0;
            r_work       <= '0;
            r_rk_data    <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_work       <= if_kx.key_in;
                r_round      <= 4'd1;
                r_rcon       <= 8'h01;
                r_keys_valid <= 1'b0;
            end else if (r_state == ST_EXPAND) begin
                r_work  <= w_wdata;
                r_round <= r_round + 4'd1;
                r_rcon  <= xtime(r_rcon);
                if (r_round == LP_NR) r_keys_valid <= 1'b1;
            end
            // Reads see the pre-edge store contents: no write-to-read bypass.
            if (if_kx.rk_addr <= LP_NR) r_rk_data <= r_store[if_kx.rk_addr];
            else                        r_rk_data <= '0;
        end
    end

    // Round-key store write; contents deliberately survive reset.
    always_ff @(posedge i_clk) begin
        if (w_we) r_store[w_waddr] <= w_wdata;
    end

    assign if_kx.key_ready  = w_key_ready;
    assign if_kx.busy       = (r_state == ST_EXPAND);
    assign if_kx.keys_valid = r_keys_valid;
    assign if_kx.rk_data    = r_rk_data;

endmodule

// File: tb/tb_aes_key_expander_seq.sv
// Self-checking bench for aes_key_expander_seq: FIPS-197 key schedules,
// handshake timing, back-to-back keys, mid-expansion reset, read-port sweep.
module tb_aes_key_expander_seq;
    import aes_key_expander_seq_pkg::*;

    typedef struct {
        string        tag;
        logic [127:0] exp;
    } sb_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_chk  = 0;
    int   n_fail = 0;
    sb_t  sb_q[$];
    logic [127:0] last_exp = '0;
    logic [127:0] exp_a1 [0:10];
    logic [127:0] exp_c1_rk1  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
    logic [127:0] exp_c1_rk10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    aes_key_expander_seq_if bus ();

    aes_key_expander_seq dut (
        .i_clk   (clk),
        .i_reset (reset),
        .if_kx   (bus)
    );

    always #5 clk = ~clk;

    // Single comparison point for every check in the bench.
    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue a read; expectation is queued now and retired when data appears.
    task automatic rd(input logic [3:0] a, input logic [127:0] e, input string tag, input bit lag);
        sb_t s;
        @(negedge clk);
        bus.rk_addr = a;
        sb_q.push_back('{tag, e});
        if (lag) begin
            #1;
            chk({tag, "_lag"}, bus.rk_data, last_exp);
        end
        @(posedge clk);
        #1;
        s = sb_q.pop_front();
        chk(s.tag, bus.rk_data, s.exp);
        last_exp = s.exp;
    endtask

    // Present a key and wait (bounded) for the accept edge; returns #1 after it.
    task automatic send_key(input logic [127:0] k, input bit hold, input logic [127:0] k_next);
        bit acc = 1'b0;
        @(negedge clk);
        bus.key_valid = 1'b1;
        bus.key_in    = k;
        for (int n = 0; n < 40 && !acc; n++) begin
            if (bus.key_ready) begin
                @(posedge clk);
                #1;
                acc = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        chk("accept", {127'd0, acc}, 128'd1);
        if (hold) begin
            bus.key_in = k_next;
        end else begin
            bus.key_valid = 1'b0;
            bus.key_in    = {4{$urandom}};
        end
    endtask

    // From just after the accept edge, check status across the 10 expansion edges.
    task automatic expect_expand(input string tag);
        chk({tag, "_busy0"}, {127'd0, bus.busy}, 128'd1);
        chk({tag, "_kv0"},   {127'd0, bus.keys_valid}, 128'd0);
        chk({tag, "_rdy0"},  {127'd0, bus.key_ready}, 128'd0);
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("%s_kv%0d", tag, i),  {127'd0, bus.keys_valid}, {127'd0, (i == 10)});
            chk($sformatf("%s_busy%0d", tag, i), {127'd0, bus.busy}, {127'd0, (i != 10)});
            chk($sformatf("%s_rdy%0d", tag, i),  {127'd0, bus.key_ready}, {127'd0, (i == 10)});
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_a1[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        exp_a1[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        exp_a1[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        exp_a1[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        exp_a1[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        exp_a1[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        exp_a1[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        exp_a1[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        exp_a1[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        exp_a1[9]  = 128'hac7766f319fadc2128d12941575c006e;
        exp_a1[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

        bus.key_valid = 1'b0;
        bus.key_in    = '0;
        bus.rk_addr   = 4'd0;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rdy",  {127'd0, bus.key_ready}, 128'd0);
        chk("rst_busy", {127'd0, bus.busy}, 128'd0);
        chk("rst_kv",   {127'd0, bus.keys_valid}, 128'd0);
        chk("rst_rd",   bus.rk_data, 128'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("idle_rdy", {127'd0, bus.key_ready}, 128'd1);

        // Vector 1: latency and known round keys; key_in scrambled after accept.
        send_key(FIPS_C1_KEY, 1'b0, '0);
        expect_expand("v1");
        rd(4'd0,  FIPS_C1_KEY, "v1_rk0",  1'b0);
        rd(4'd1,  exp_c1_rk1,  "v1_rk1",  1'b1);
        rd(4'd10, exp_c1_rk10, "v1_rk10", 1'b1);

        // Vector 2: full sweep 0..15, out-of-range reads return zero.
        send_key(FIPS_A1_KEY, 1'b0, '0);
        expect_expand("v2");
        for (int a = 0; a < 16; a++) begin
            rd(4'(a), (a <= 10) ? exp_a1[a] : 128'd0, $sformatf("v2_rk%0d", a), (a != 0));
        end

        // Reset in the middle of expansion.
        send_key(FIPS_A1_KEY, 1'b0, '0);
        repeat (5) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_busy", {127'd0, bus.busy}, 128'd0);
        chk("mid_kv",   {127'd0, bus.keys_valid}, 128'd0);
        chk("mid_rdy",  {127'd0, bus.key_ready}, 128'd0);
        chk("mid_rd",   bus.rk_data, 128'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("mid_rdy_rel", {127'd0, bus.key_ready}, 128'd1);
        send_key(FIPS_C1_KEY, 1'b0, '0);
        expect_expand("rerun");
        rd(4'd10, exp_c1_rk10, "rerun_rk10", 1'b0);

        // Back-to-back keys with key_valid held high throughout.
        send_key(FIPS_C1_KEY, 1'b1, FIPS_A1_KEY);
        expect_expand("b2b1");
        @(posedge clk);
        #1;
        chk("b2b_kv_drop", {127'd0, bus.keys_valid}, 128'd0);
        bus.key_valid = 1'b0;
        bus.key_in    = {4{$urandom}};
        chk("b2b_busy", {127'd0, bus.busy}, 128'd1);
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("b2b2_kv%0d", i), {127'd0, bus.keys_valid}, {127'd0, (i == 10)});
        end
        rd(4'd1,  exp_a1[1],  "b2b_rk1",  1'b0);
        rd(4'd10, exp_a1[10], "b2b_rk10", 1'b1);
        chk("sb_empty", 128'(sb_q.size()), 128'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
